// File: rtl/riscv_pkg.sv
// Shared pipeline constants and the IF/ID payload type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // addi x0,x0,0 with a zeroed PC; decode treats it as a harmless no-op.
  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: async reset and flush load a bubble, stall holds every field.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic [XLEN-1:0] instr_f,
  input  logic [XLEN-1:0] pc_f,
  input  logic [XLEN-1:0] pc_plus4_f,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  if_id_t stage_q;
  if_id_t stage_d;

  // Flush outranks stall so a killed wrong-path instruction cannot be held.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = BUBBLE;
    end else if (!stall) begin
      stage_d = '{instr: instr_f, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign instr_d    = stage_q.instr;
  assign pc_d       = stage_q.pc;
  assign pc_plus4_d = stage_q.pc_plus4;
  assign valid_d    = stage_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the IF/ID register feeding Decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ImemRdF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^PCTargetE[1:0];
  assign pc_plus4 = pc_q + PC_STEP;

  // A redirect beats StallF so a taken branch is never dropped.
  always_comb begin
    pc_next = pc_plus4;
    if (PCSrcE) begin
      pc_next = {PCTargetE[31:2], 2'b00};
    end else if (StallF) begin
      pc_next = pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc_q <= pc_next;
    end
  end

  assign PCF = pc_q;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .flush      (FlushD),
    .stall      (StallD),
    .instr_f    (ImemRdF),
    .pc_f       (pc_q),
    .pc_plus4_f (pc_plus4),
    .instr_d    (InstrD),
    .pc_d       (PCD),
    .pc_plus4_d (PCPlus4D),
    .valid_d    (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, redirect, stalls, PC wrap, async reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, ImemRdF, PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  // Second instance exercises a reset PC near the top of the address space.
  logic        reset_w;
  logic [31:0] ImemRdF_w, PCF_w, InstrD_w, PCD_w, PCPlus4D_w;
  logic        ValidD_w;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Instruction memory model: a word derived from its address.
  function automatic logic [31:0] iw(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  assign ImemRdF   = iw(PCF);
  assign ImemRdF_w = iw(PCF_w);

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .ImemRdF   (ImemRdF),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_w (
    .clk       (clk),
    .reset     (reset_w),
    .StallF    (1'b0),
    .StallD    (1'b0),
    .FlushD    (1'b0),
    .PCSrcE    (1'b0),
    .PCTargetE (32'h0),
    .ImemRdF   (ImemRdF_w),
    .PCF       (PCF_w),
    .InstrD    (InstrD_w),
    .PCD       (PCD_w),
    .PCPlus4D  (PCPlus4D_w),
    .ValidD    (ValidD_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
  endtask

  task automatic test_reset();
    logic [128:0] exp_v;
    clear_ctrl();
    reset = 1'b1;
    reset_w = 1'b1;
    #1;
    exp_v = {32'h0, NOP, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", {PCF, InstrD, PCD, PCPlus4D, ValidD}, exp_v);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [128:0] exp_v;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_v = {32'(4 * i), iw(32'(4 * (i - 1))), 32'(4 * (i - 1)), 32'(4 * i), 1'b1};
      n_checks++;
      if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
        n_fail++;
        $display("FAIL seq_step%0d: got %h want %h", i, {PCF, InstrD, PCD, PCPlus4D, ValidD},
                 exp_v);
      end
    end
  endtask

  task automatic test_redirect();
    logic [128:0] exp_v;
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h43;
    tick();
    clear_ctrl();
    exp_v = {32'h40, NOP, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
      n_fail++;
      $display("FAIL redirect_bubble: got %h want %h", {PCF, InstrD, PCD, PCPlus4D, ValidD}, exp_v);
    end
    tick();
    exp_v = {32'h44, iw(32'h40), 32'h40, 32'h44, 1'b1};
    n_checks++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
      n_fail++;
      $display("FAIL redirect_target: got %h want %h", {PCF, InstrD, PCD, PCPlus4D, ValidD}, exp_v);
    end
  endtask

  task automatic test_stall();
    logic [128:0] exp_v;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    tick();
    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {32'h8, iw(32'h4), 32'h4, 32'h8, 1'b1};
      n_checks++;
      if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h want %h", i, {PCF, InstrD, PCD, PCPlus4D, ValidD},
                 exp_v);
      end
    end
    clear_ctrl();
    tick();
    exp_v = {32'hC, iw(32'h8), 32'h8, 32'hC, 1'b1};
    n_checks++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
      n_fail++;
      $display("FAIL stall_resume: got %h want %h", {PCF, InstrD, PCD, PCPlus4D, ValidD}, exp_v);
    end
  endtask

  task automatic test_redirect_over_stall();
    logic [128:0] exp_v;
    StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h100;
    tick();
    clear_ctrl();
    exp_v = {32'h100, NOP, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
      n_fail++;
      $display("FAIL redirect_over_stall: got %h want %h", {PCF, InstrD, PCD, PCPlus4D, ValidD},
               exp_v);
    end
    tick();
    exp_v = {32'h104, iw(32'h100), 32'h100, 32'h104, 1'b1};
    n_checks++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
      n_fail++;
      $display("FAIL after_stall_redirect: got %h want %h", {PCF, InstrD, PCD, PCPlus4D, ValidD},
               exp_v);
    end
  endtask

  task automatic test_wrap();
    logic [128:0] exp_v;
    logic [31:0]  exp_pcf [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    logic [31:0]  exp_p4 [4] = '{32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4};
    n_checks++;
    if (PCF_w !== exp_pcf[0] || ValidD_w !== 1'b0 || InstrD_w !== NOP) begin
      n_fail++;
      $display("FAIL wrap_reset: got pcf=%h instr=%h valid=%b want pcf=%h instr=%h valid=0",
               PCF_w, InstrD_w, ValidD_w, exp_pcf[0], NOP);
    end
    reset_w = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      exp_v = {exp_pcf[i], iw(exp_pcf[i-1]), exp_pcf[i-1], exp_p4[i], 1'b1};
      n_checks++;
      if ({PCF_w, InstrD_w, PCD_w, PCPlus4D_w, ValidD_w} !== exp_v) begin
        n_fail++;
        $display("FAIL wrap_step%0d: got %h want %h", i,
                 {PCF_w, InstrD_w, PCD_w, PCPlus4D_w, ValidD_w}, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [128:0] exp_v;
    StallF = 1'b1; StallD = 1'b1;
    #3;
    reset = 1'b1;
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    #1;
    exp_v = {32'h0, NOP, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", {PCF, InstrD, PCD, PCPlus4D, ValidD}, exp_v);
    end
    tick();
    n_checks++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_drops_redirect: got %h want %h", {PCF, InstrD, PCD, PCPlus4D, ValidD},
               exp_v);
    end
    clear_ctrl();
    reset = 1'b0;
    tick();
    exp_v = {32'h4, iw(32'h0), 32'h0, 32'h4, 1'b1};
    n_checks++;
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== exp_v) begin
      n_fail++;
      $display("FAIL restart_fetch: got %h want %h", {PCF, InstrD, PCD, PCPlus4D, ValidD}, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_redirect_over_stall();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
